// File: rtl/spi_adc_pkg.sv
// Shared types and constants for the SPI ADC responder (sonar ADC emulator).
// Edge helpers operate on a current/previous register pair of a staged input.
package spi_adc_pkg;

    localparam int ADC_DATA_WIDTH = 16;
    localparam int ADC_FIFO_DEPTH = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_resp_state_t;

    function automatic logic rise_detect(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

    function automatic logic fall_detect(input logic cur, input logic prev);
        return ~cur & prev;
    endfunction

endpackage

// File: rtl/spi_adc_responder_sample_fifo.sv
// Synchronous sample FIFO: ready/valid push, pop strobe, head data and occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo
    import spi_adc_pkg::*;
#(
    parameter int WIDTH = ADC_DATA_WIDTH,
    parameter int DEPTH = ADC_FIFO_DEPTH
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             ready_q;
    logic             push_s;
    logic             pop_s;

    assign push_s = push_valid_i & ready_q;
    assign pop_s  = pop_i & (count_q != {CW{1'b0}});

    // Next occupancy: a simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and ready registers; ready stays low while in reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            ready_q  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d < CNT_DEPTH);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign push_ready_o = ready_q;
    assign head_data_o  = mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI peripheral emulating the sonar ADC: serializes one queued sample MSB-first per cs frame.
// Define SPI_ADC_RESPONDER_SYNC_EN to add two-flop synchronizers on dclk/cs.
module spi_adc_responder
    import spi_adc_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_DATA_WIDTH,
    parameter int FIFO_DEPTH = ADC_FIFO_DEPTH
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         sample_in,
    input  logic                          sample_valid_in,
    output logic                          sample_ready_out,
    input  logic                          chip_clk_in,
    input  logic                          chip_sel_in,
    output logic                          chip_data_out,
    output logic                          frame_done_out,
    output logic                          frame_abort_out,
    output logic                          underrun_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_WIDTH + 1);

    logic                  sclk_stage_s;
    logic                  cs_stage_s;
    logic                  sclk_cur_q;
    logic                  sclk_prev_q;
    logic                  cs_cur_q;
    logic                  cs_prev_q;
    logic                  sclk_rise_s;
    logic                  sclk_fall_s;
    logic                  cs_rise_s;
    logic                  cs_fall_s;
    logic                  pop_s;
    logic                  fifo_empty_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic [CW-1:0]         count_s;

    spi_resp_state_t       state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  data_q;
    logic                  done_q;
    logic                  abort_q;
    logic                  underrun_q;

`ifdef SPI_ADC_RESPONDER_SYNC_EN
    logic [1:0] sclk_sync_q;
    logic [1:0] cs_sync_q;

    // Two-flop synchronizers for a controller in a foreign clock domain.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], chip_clk_in};
            cs_sync_q   <= {cs_sync_q[0], chip_sel_in};
        end
    end

    assign sclk_stage_s = sclk_sync_q[1];
    assign cs_stage_s   = cs_sync_q[1];
`else
    assign sclk_stage_s = chip_clk_in;
    assign cs_stage_s   = chip_sel_in;
`endif

    // Current/previous registers of the staged pins; cs idles high so reset shows no edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sclk_cur_q  <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_cur_q    <= 1'b1;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_cur_q  <= sclk_stage_s;
            sclk_prev_q <= sclk_cur_q;
            cs_cur_q    <= cs_stage_s;
            cs_prev_q   <= cs_cur_q;
        end
    end

    assign sclk_rise_s  = rise_detect(sclk_cur_q, sclk_prev_q);
    assign sclk_fall_s  = fall_detect(sclk_cur_q, sclk_prev_q);
    assign cs_rise_s    = rise_detect(cs_cur_q, cs_prev_q);
    assign cs_fall_s    = fall_detect(cs_cur_q, cs_prev_q);
    assign fifo_empty_s = (count_s == {CW{1'b0}});
    // A push landing in the frame-start cycle is not yet counted, so that frame underruns.
    assign pop_s        = (state_q == IDLE) & cs_fall_s & ~fifo_empty_s;

    sample_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .push_data_i  (sample_in),
        .push_valid_i (sample_valid_in),
        .push_ready_o (sample_ready_out),
        .pop_i        (pop_s),
        .head_data_o  (head_s),
        .count_o      (count_s)
    );

    // Frame FSM with shift register, bit counter and registered status outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= {DATA_WIDTH{1'b0}};
            bit_cnt_q  <= {CNT_W{1'b0}};
            data_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    bit_cnt_q <= {CNT_W{1'b0}};
                    if (cs_fall_s) begin
                        state_q <= SHIFT;
                        if (!fifo_empty_s) begin
                            shift_q <= head_s;
                            data_q  <= head_s[DATA_WIDTH-1];
                        end else begin
                            shift_q    <= {DATA_WIDTH{1'b0}};
                            data_q     <= 1'b0;
                            underrun_q <= 1'b1;
                        end
                    end else begin
                        shift_q <= {DATA_WIDTH{1'b0}};
                        data_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    // cs rise takes priority over any coincident dclk edge.
                    if (cs_rise_s) begin
                        state_q   <= IDLE;
                        shift_q   <= {DATA_WIDTH{1'b0}};
                        bit_cnt_q <= {CNT_W{1'b0}};
                        data_q    <= 1'b0;
                        if (bit_cnt_q == CNT_FULL) begin
                            done_q <= 1'b1;
                        end else begin
                            abort_q <= 1'b1;
                        end
                    end else if (sclk_rise_s) begin
                        if (bit_cnt_q != CNT_SAT) begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else if (sclk_fall_s) begin
                        shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                        data_q  <= shift_q[DATA_WIDTH-2];
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    shift_q   <= {DATA_WIDTH{1'b0}};
                    bit_cnt_q <= {CNT_W{1'b0}};
                    data_q    <= 1'b0;
                end
            endcase
        end
    end

    assign chip_data_out   = data_q;
    assign frame_done_out  = done_q;
    assign frame_abort_out = abort_q;
    assign underrun_out    = underrun_q;
    assign fifo_count_out  = count_s;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: a behavioural SPI controller drives dclk/cs and
// samples cipo just before each dclk rising edge.
module tb_spi_adc_responder;

`ifdef SPI_ADC_RESPONDER_SYNC_EN
    localparam int HP  = 5;
    localparam int LAT = 4;
`else
    localparam int HP  = 3;
    localparam int LAT = 2;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        sample_valid_in = 1'b0;
    logic        sample_ready_out;
    logic        chip_clk_in = 1'b0;
    logic        chip_sel_in = 1'b1;
    logic        chip_data_out;
    logic        frame_done_out;
    logic        frame_abort_out;
    logic        underrun_out;
    logic [3:0]  fifo_count_out;

    int n_total = 0;
    int n_bad   = 0;
    int n_done  = 0;
    int n_abort = 0;
    int n_under = 0;
    int n_rdy_lo = 0;

    spi_adc_responder #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_in           (clk_in),
        .rst_n            (rst_n),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
        .chip_clk_in      (chip_clk_in),
        .chip_sel_in      (chip_sel_in),
        .chip_data_out    (chip_data_out),
        .frame_done_out   (frame_done_out),
        .frame_abort_out  (frame_abort_out),
        .underrun_out     (underrun_out),
        .fifo_count_out   (fifo_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Pulse and ready-low counters sampled on the opposite clock edge.
    always @(negedge clk_in) begin
        if (frame_done_out)  n_done++;
        if (frame_abort_out) n_abort++;
        if (underrun_out)    n_under++;
        if (rst_n && !sample_ready_out) n_rdy_lo++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        sample_in = d;
        sample_valid_in = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (sample_ready_out) ok = 1'b1;
            tick(1);
        end
        sample_valid_in = 1'b0;
        chk("push_accept", {31'd0, ok}, 32'd1);
    endtask

    // One controller frame; optionally pushes inj_data in the cycle the responder starts the frame.
    task automatic spi_frame(input int nedges, input bit inject, input logic [15:0] inj_data,
                             output logic [15:0] rx, output int lat);
        rx = 16'h0000;
        lat = 0;
        chip_sel_in = 1'b0;
        for (int k = 1; k <= HP; k++) begin
            if (inject) begin
                sample_valid_in = (k == LAT);
                sample_in = inj_data;
            end
            tick(1);
            if (chip_data_out && lat == 0) lat = k;
        end
        if (inject) sample_valid_in = 1'b0;
        for (int i = 0; i < nedges; i++) begin
            rx = {rx[14:0], chip_data_out};
            chip_clk_in = 1'b1;
            tick(HP);
            chip_clk_in = 1'b0;
            tick(HP);
        end
        chip_sel_in = 1'b1;
        tick(4);
    endtask

    logic [15:0] rx;
    int          lat;
    int          d0, a0, u0, r0;
    logic [15:0] exp_d;

    initial begin
        // Reset state
        tick(3);
        chk("rst_ready", {31'd0, sample_ready_out}, 32'd0);
        chk("rst_cipo", {31'd0, chip_data_out}, 32'd0);
        chk("rst_count", {28'd0, fifo_count_out}, 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_rst", {31'd0, sample_ready_out}, 32'd1);

        // Single frame
        push(16'hA5C3);
        chk("single_cnt_before", {28'd0, fifo_count_out}, 32'd1);
        d0 = n_done; a0 = n_abort;
        spi_frame(16, 1'b0, 16'h0000, rx, lat);
        chk("single_rx", {16'd0, rx}, 32'h0000A5C3);
        chk("single_latency", lat, LAT);
        chk("single_done", n_done - d0, 32'd1);
        chk("single_abort", n_abort - a0, 32'd0);
        chk("single_cnt_after", {28'd0, fifo_count_out}, 32'd0);
        chk("idle_cipo", {31'd0, chip_data_out}, 32'd0);

        // Back-to-back frames
        push(16'h0001);
        push(16'h8000);
        push(16'hFFFF);
        r0 = n_rdy_lo; d0 = n_done;
        spi_frame(16, 1'b0, 16'h0000, rx, lat);
        chk("b2b_rx0", {16'd0, rx}, 32'h00000001);
        spi_frame(16, 1'b0, 16'h0000, rx, lat);
        chk("b2b_rx1", {16'd0, rx}, 32'h00008000);
        spi_frame(16, 1'b0, 16'h0000, rx, lat);
        chk("b2b_rx2", {16'd0, rx}, 32'h0000FFFF);
        chk("b2b_ready_high", n_rdy_lo - r0, 32'd0);
        chk("b2b_done", n_done - d0, 32'd3);

        // Underrun with a push in the frame-start cycle
        u0 = n_under;
        spi_frame(16, 1'b1, 16'h5A5A, rx, lat);
        chk("under_rx", {16'd0, rx}, 32'h00000000);
        chk("under_pulse", n_under - u0, 32'd1);
        chk("under_kept", {28'd0, fifo_count_out}, 32'd1);
        spi_frame(16, 1'b0, 16'h0000, rx, lat);
        chk("under_next_rx", {16'd0, rx}, 32'h00005A5A);
        chk("under_no_repeat", n_under - u0, 32'd1);

        // Full FIFO: ninth push held until a frame pops
        for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i));
        chk("full_ready", {31'd0, sample_ready_out}, 32'd0);
        chk("full_count", {28'd0, fifo_count_out}, 32'd8);
        sample_in = 16'h1008;
        sample_valid_in = 1'b1;
        tick(3);
        chk("full_held_ready", {31'd0, sample_ready_out}, 32'd0);
        chk("full_held_count", {28'd0, fifo_count_out}, 32'd8);
        spi_frame(16, 1'b0, 16'h0000, rx, lat);
        sample_valid_in = 1'b0;
        chk("full_rx0", {16'd0, rx}, 32'h00001000);
        chk("full_ninth_in", {28'd0, fifo_count_out}, 32'd8);
        for (int i = 1; i <= 8; i++) begin
            spi_frame(16, 1'b0, 16'h0000, rx, lat);
            exp_d = 16'h1000 + 16'(i);
            chk("full_drain", {16'd0, rx}, {16'd0, exp_d});
        end
        chk("full_empty", {28'd0, fifo_count_out}, 32'd0);

        // Abort after 7 edges, then normal frame with the next entry
        push(16'h1111);
        push(16'h2222);
        d0 = n_done; a0 = n_abort;
        spi_frame(7, 1'b0, 16'h0000, rx, lat);
        chk("abort_short", n_abort - a0, 32'd1);
        chk("abort_no_done", n_done - d0, 32'd0);
        spi_frame(16, 1'b0, 16'h0000, rx, lat);
        chk("abort_next_rx", {16'd0, rx}, 32'h00002222);
        chk("abort_next_done", n_done - d0, 32'd1);
        push(16'h3333);
        a0 = n_abort;
        spi_frame(17, 1'b0, 16'h0000, rx, lat);
        chk("abort_long", n_abort - a0, 32'd1);
        chk("abort_long_done", n_done - d0, 32'd1);

        // Reset mid-frame
        push(16'h4444);
        push(16'h5555);
        chip_sel_in = 1'b0;
        tick(HP);
        chip_clk_in = 1'b1;
        tick(HP);
        chk("mid_cipo_before", {31'd0, chip_data_out}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cipo", {31'd0, chip_data_out}, 32'd0);
        chk("mid_rst_count", {28'd0, fifo_count_out}, 32'd0);
        chk("mid_rst_ready", {31'd0, sample_ready_out}, 32'd0);
        chk("mid_rst_pulses", {29'd0, frame_done_out, frame_abort_out, underrun_out}, 32'd0);
        chip_clk_in = 1'b0;
        chip_sel_in = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_ready", {31'd0, sample_ready_out}, 32'd1);
        u0 = n_under;
        spi_frame(16, 1'b0, 16'h0000, rx, lat);
        chk("post_rst_rx", {16'd0, rx}, 32'h00000000);
        chk("post_rst_under", n_under - u0, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
